// File: rtl/issue_cmd_dispatch_if.sv
// Bundle between the issue FIFO, the command dispatcher and the DRAM command pins.
// The master side drives the FIFO head and enable; the slave side is the dispatcher.
interface issue_cmd_dispatch_if;
    logic        en;
    logic        fifo_empty;
    logic [20:0] fifo_data;
    logic        fifo_ren;
    logic        ddr_cs_n;
    logic        ddr_ras_n;
    logic        ddr_cas_n;
    logic        ddr_we_n;
    logic [13:0] ddr_addr;
    logic [2:0]  ddr_ba;
    logic        rd_issue;
    logic        wr_issue;
    logic        busy;
    logic        bad_cmd;

    modport master (
        output en, fifo_empty, fifo_data,
        input  fifo_ren, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n,
        input  ddr_addr, ddr_ba, rd_issue, wr_issue, busy, bad_cmd
    );

    modport slave (
        input  en, fifo_empty, fifo_data,
        output fifo_ren, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n,
        output ddr_addr, ddr_ba, rd_issue, wr_issue, busy, bad_cmd
    );
endinterface

// File: rtl/issue_cmd_dispatch.sv
// Pops DRAM commands from the issue FIFO and drives them onto the command pins for one
// cycle each, holding off the next pop until the per-command spacing has elapsed.
module issue_cmd_dispatch #(
    parameter int T_RCD = 4,
    parameter int T_RP  = 4,
    parameter int T_CCD = 2,
    parameter int T_RFC = 16,
    parameter int T_MRD = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    issue_cmd_dispatch_if.slave   bus
);
    localparam logic [3:0] C_NOP  = 4'd0;
    localparam logic [3:0] C_ACT  = 4'd1;
    localparam logic [3:0] C_RD   = 4'd2;
    localparam logic [3:0] C_WR   = 4'd3;
    localparam logic [3:0] C_PRE  = 4'd4;
    localparam logic [3:0] C_PREA = 4'd5;
    localparam logic [3:0] C_REF  = 4'd6;
    localparam logic [3:0] C_MRS  = 4'd7;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t      r_state, w_state_next;
    logic [4:0]  r_gap, w_gap_next, w_gap_load;
    logic [3:0]  r_cmd;
    logic        w_pop;
    logic [3:0]  w_cmd;
    logic [3:0]  r_pins, w_pins;
    logic [13:0] r_addr, w_addr;
    logic [2:0]  r_ba;
    logic        r_rd, r_wr, r_bad, w_bad;

    assign w_cmd = bus.fifo_data[20:17];

    // Pins are loaded at the pop edge so the command is visible during the ISSUE cycle.
    always_comb begin
        w_pins = 4'b0111;
        w_addr = bus.fifo_data[16:3];
        w_bad  = 1'b0;
        case (w_cmd)
            C_NOP:   w_pins = 4'b0111;
            C_ACT:   w_pins = 4'b0011;
            C_RD:    w_pins = 4'b0101;
            C_WR:    w_pins = 4'b0100;
            C_PRE:   begin w_pins = 4'b0010; w_addr[10] = 1'b0; end
            C_PREA:  begin w_pins = 4'b0010; w_addr[10] = 1'b1; end
            C_REF:   w_pins = 4'b0001;
            C_MRS:   w_pins = 4'b0000;
            default: w_bad  = 1'b1;
        endcase
    end

    // Gap loads W-2: one cycle is the ISSUE itself, one is the pop cycle that follows.
    always_comb begin
        w_gap_load = 5'd0;
        case (r_cmd)
            C_ACT:        w_gap_load = 5'(T_RCD - 2);
            C_RD, C_WR:   w_gap_load = 5'(T_CCD - 2);
            C_PRE, C_PREA: w_gap_load = 5'(T_RP - 2);
            C_REF:        w_gap_load = 5'(T_RFC - 2);
            C_MRS:        w_gap_load = 5'(T_MRD - 2);
            default:      w_gap_load = 5'd0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_gap_next   = r_gap;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_gap != 5'd0) begin
                    w_gap_next = r_gap - 5'd1;
                end else if (bus.en && !bus.fifo_empty && rst_n) begin
                    w_pop        = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_IDLE;
                w_gap_next   = w_gap_load;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gap   <= 5'd0;
            r_cmd   <= 4'd0;
            r_pins  <= 4'b1111;
            r_addr  <= 14'd0;
            r_ba    <= 3'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_gap   <= w_gap_next;
            if (w_pop) begin
                r_cmd  <= w_cmd;
                r_pins <= w_pins;
                r_addr <= w_addr;
                r_ba   <= bus.fifo_data[2:0];
                r_rd   <= (w_cmd == C_RD);
                r_wr   <= (w_cmd == C_WR);
                r_bad  <= w_bad;
            end else begin
                r_pins <= 4'b1111;
                r_rd   <= 1'b0;
                r_wr   <= 1'b0;
                r_bad  <= 1'b0;
            end
        end
    end

    assign bus.fifo_ren  = w_pop;
    assign bus.ddr_cs_n  = r_pins[3];
    assign bus.ddr_ras_n = r_pins[2];
    assign bus.ddr_cas_n = r_pins[1];
    assign bus.ddr_we_n  = r_pins[0];
    assign bus.ddr_addr  = r_addr;
    assign bus.ddr_ba    = r_ba;
    assign bus.rd_issue  = r_rd;
    assign bus.wr_issue  = r_wr;
    assign bus.bad_cmd   = r_bad;
    assign bus.busy      = (r_state == S_ISSUE) || (r_gap != 5'd0);
endmodule

// File: tb/tb_issue_cmd_dispatch.sv
// Self-checking bench: FIFO model feeds the dispatcher, a scoreboard holds expected pin
// cycles and the spacing from the previous command.
module tb_issue_cmd_dispatch;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    issue_cmd_dispatch_if bus();

    issue_cmd_dispatch #(.T_RCD(4), .T_RP(4), .T_CCD(2), .T_RFC(16), .T_MRD(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  pins;
        logic [13:0] addr;
        logic [2:0]  ba;
        logic        rd, wr, bad;
        int          w;
        bit          chk_gap;
    } exp_t;

    typedef struct {
        logic [3:0]  cmd;
        logic [13:0] addr;
        logic [2:0]  ba;
        logic [3:0]  pins;
        logic [13:0] eaddr;
        logic [2:0]  eba;
        logic        rd, wr, bad;
        int          w;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ren_cnt = 0;
    logic [20:0] fq[$];
    exp_t        sb[$];
    vec_t        tbl[11];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        bus.fifo_empty = (fq.size() == 0);
        bus.fifo_data  = (fq.size() != 0) ? fq[0] : 21'd0;
    endtask

    // One clock: fifo_ren is sampled mid-cycle, the model pops just after the edge.
    task automatic tick();
        logic ren;
        @(negedge clk);
        ren = bus.fifo_ren;
        if (ren && bus.fifo_empty) begin
            errors++;
            $display("FAIL pop_when_empty: fifo_ren=1 required 0 (cycle %0d)", cyc);
        end
        @(posedge clk);
        #1;
        if (ren) begin
            ren_cnt++;
            if (fq.size() != 0) void'(fq.pop_front());
        end
        refresh();
    endtask

    task automatic push(input vec_t v, input bit chk_gap);
        exp_t e;
        fq.push_back({v.cmd, v.addr, v.ba});
        e.pins = v.pins; e.addr = v.eaddr; e.ba = v.eba;
        e.rd = v.rd; e.wr = v.wr; e.bad = v.bad; e.w = v.w; e.chk_gap = chk_gap;
        sb.push_back(e);
        refresh();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout: %0d commands still pending, required 0", name, sb.size());
        end
    endtask

    task automatic wait_issue(input string name);
        int n;
        n = 0;
        while (bus.ddr_cs_n && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_issue_seen"}, 32'(bus.ddr_cs_n), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pins"}, {bus.ddr_cs_n, bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n}, 4'hF);
        chk({tag, "_addr_ba"}, {bus.ddr_addr, bus.ddr_ba}, 17'd0);
        chk({tag, "_flags"}, {bus.fifo_ren, bus.rd_issue, bus.wr_issue, bus.bad_cmd, bus.busy}, 5'd0);
    endtask

    // Monitor: every cycle with cs_n low is a command and must match the scoreboard head.
    int   last_cyc = 0;
    int   last_w = 0;
    bit   prev_sel = 1'b0;
    exp_t e_mon;
    always @(negedge clk) begin
        if (rst_n && !bus.ddr_cs_n) begin
            if (prev_sel) begin
                errors++;
                $display("FAIL no_deselect: cs_n=0 on consecutive cycles, required 1 (cycle %0d)", cyc);
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cmd: pins=%b with empty scoreboard (cycle %0d)",
                         {bus.ddr_cs_n, bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n}, cyc);
            end else begin
                e_mon = sb.pop_front();
                $display("cyc %0d cmd pins=%b addr=%h ba=%0d rd=%b wr=%b bad=%b", cyc,
                         {bus.ddr_cs_n, bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n},
                         bus.ddr_addr, bus.ddr_ba, bus.rd_issue, bus.wr_issue, bus.bad_cmd);
                chk("pins", {bus.ddr_cs_n, bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n}, e_mon.pins);
                chk("addr", bus.ddr_addr, e_mon.addr);
                chk("ba", bus.ddr_ba, e_mon.ba);
                chk("pulses", {bus.rd_issue, bus.wr_issue, bus.bad_cmd}, {e_mon.rd, e_mon.wr, e_mon.bad});
                if (e_mon.chk_gap) chk("spacing", cyc - last_cyc, last_w);
                last_cyc = cyc;
                last_w   = e_mon.w;
            end
        end else if (bus.rd_issue || bus.wr_issue || bus.bad_cmd) begin
            errors++;
            $display("FAIL stray_pulse: rd/wr/bad=%b%b%b without command, required 000 (cycle %0d)",
                     bus.rd_issue, bus.wr_issue, bus.bad_cmd, cyc);
        end
        prev_sel = rst_n && !bus.ddr_cs_n;
    end

    initial begin
        int   ren0;
        vec_t v;

        //         cmd    addr      ba    pins     exp addr  ba    rd    wr    bad   W
        tbl[0]  = '{4'd1,  14'h01A5, 3'd2, 4'b0011, 14'h01A5, 3'd2, 1'b0, 1'b0, 1'b0, 4};
        tbl[1]  = '{4'd2,  14'h0040, 3'd2, 4'b0101, 14'h0040, 3'd2, 1'b1, 1'b0, 1'b0, 2};
        tbl[2]  = '{4'd3,  14'h0080, 3'd6, 4'b0100, 14'h0080, 3'd6, 1'b0, 1'b1, 1'b0, 2};
        tbl[3]  = '{4'd4,  14'h3FFF, 3'd5, 4'b0010, 14'h3BFF, 3'd5, 1'b0, 1'b0, 1'b0, 4};
        tbl[4]  = '{4'd5,  14'h0000, 3'd0, 4'b0010, 14'h0400, 3'd0, 1'b0, 1'b0, 1'b0, 4};
        tbl[5]  = '{4'd6,  14'h0000, 3'd0, 4'b0001, 14'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 16};
        tbl[6]  = '{4'd7,  14'h0123, 3'd3, 4'b0000, 14'h0123, 3'd3, 1'b0, 1'b0, 1'b0, 2};
        tbl[7]  = '{4'd0,  14'h1555, 3'd1, 4'b0111, 14'h1555, 3'd1, 1'b0, 1'b0, 1'b0, 2};
        tbl[8]  = '{4'd12, 14'h0AAA, 3'd4, 4'b0111, 14'h0AAA, 3'd4, 1'b0, 1'b0, 1'b1, 2};
        tbl[9]  = '{4'd9,  14'h0011, 3'd7, 4'b0111, 14'h0011, 3'd7, 1'b0, 1'b0, 1'b1, 2};
        tbl[10] = '{4'd1,  14'h2001, 3'd0, 4'b0011, 14'h2001, 3'd0, 1'b0, 1'b0, 1'b0, 4};

        rst_n  = 1'b0;
        bus.en = 1'b0;
        refresh();
        repeat (3) tick();
        chk_reset("reset");
        rst_n  = 1'b1;
        bus.en = 1'b1;
        tick();

        // Back-to-back table: spacing between each pair equals W of the earlier command.
        for (int i = 0; i < 11; i++) push(tbl[i], i != 0);
        drain("table");

        // Four consecutive writes.
        ren0 = ren_cnt;
        v = '{4'd3, 14'h0100, 3'd1, 4'b0100, 14'h0100, 3'd1, 1'b0, 1'b1, 1'b0, 2};
        for (int i = 0; i < 4; i++) push(v, i != 0);
        drain("wr4");
        chk("wr4_pops", ren_cnt - ren0, 32'd4);

        // Single ACT followed by an empty FIFO.
        push(tbl[0], 1'b0);
        wait_issue("act_empty");
        ren0 = ren_cnt;
        tick(); chk("busy_k1", 32'(bus.busy), 32'd1);
        tick(); chk("busy_k2", 32'(bus.busy), 32'd1);
        tick(); chk("busy_k3", 32'(bus.busy), 32'd0);
        repeat (7) tick();
        chk("empty_deselect", 32'(bus.ddr_cs_n), 32'd1);
        chk("empty_no_pop", ren_cnt - ren0, 32'd0);

        // Enable low with data waiting: no pop until enabled.
        bus.en = 1'b0;
        push(tbl[7], 1'b0);
        ren0 = ren_cnt;
        repeat (5) tick();
        chk("en_low_no_pop", ren_cnt - ren0, 32'd0);
        bus.en = 1'b1;
        drain("en_low");

        // Reset in the refresh gap: pending ACT pops right after release.
        v = '{4'd6, 14'h02AA, 3'd1, 4'b0001, 14'h02AA, 3'd1, 1'b0, 1'b0, 1'b0, 16};
        push(v, 1'b0);
        push(tbl[10], 1'b0);
        wait_issue("ref_rst");
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk_reset("mid_reset");
        rst_n = 1'b1;
        tick();
        chk("post_reset_issue", 32'(bus.ddr_cs_n), 32'd0);
        drain("post_reset");

        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("fifo_empty_end", fq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
